// File: rtl/adc_capture_ctrl_if.sv
// Register port, ADC sample input and AXI-Stream master signals of adc_capture_ctrl.
// CAPTURE_TRIGGER_EN adds the synchronous trig input.
interface adc_capture_ctrl_if #(
    parameter int REG_AW = 4
);
    logic              reg_wr;
    logic [REG_AW-1:0] reg_addr;
    logic [31:0]       reg_wdata;
    logic              reg_rd;
    logic [31:0]       reg_rdata;
    logic              adc_valid;
    logic [15:0]       adc_data;
    logic [31:0]       m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              irq_done;
`ifdef CAPTURE_TRIGGER_EN
    logic              trig;

    modport master (
        input  reg_wr, reg_addr, reg_wdata, reg_rd, adc_valid, adc_data, m_axis_tready, trig,
        output reg_rdata, m_axis_tdata, m_axis_tvalid, m_axis_tlast, irq_done
    );
    modport slave (
        output reg_wr, reg_addr, reg_wdata, reg_rd, adc_valid, adc_data, m_axis_tready, trig,
        input  reg_rdata, m_axis_tdata, m_axis_tvalid, m_axis_tlast, irq_done
    );
`else
    modport master (
        input  reg_wr, reg_addr, reg_wdata, reg_rd, adc_valid, adc_data, m_axis_tready,
        output reg_rdata, m_axis_tdata, m_axis_tvalid, m_axis_tlast, irq_done
    );
    modport slave (
        output reg_wr, reg_addr, reg_wdata, reg_rd, adc_valid, adc_data, m_axis_tready,
        input  reg_rdata, m_axis_tdata, m_axis_tvalid, m_axis_tlast, irq_done
    );
`endif
endinterface

// File: rtl/adc_capture_ctrl.sv
// Packs 16-bit ADC samples into 32-bit AXI-Stream beats for a DMA S2MM packet of SIZE bytes.
// Optional CAPTURE_TRIGGER_EN: START arms the block and the first trig rising edge begins capture.
module adc_capture_ctrl #(
    parameter int SIZE_W = 32,
    parameter int REG_AW = 4
) (
    input logic               clk,
    input logic               resetn,
    adc_capture_ctrl_if.master bus
);
    localparam int CW = SIZE_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_DRAIN,
        S_FLUSH
`ifdef CAPTURE_TRIGGER_EN
        , S_ARMED
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [CW-1:0]     beat_q, beat_d;
    logic [CW-1:0]     count_q, count_d;
    logic [15:0]       half_q, half_d;
    logic              half_vld_q, half_vld_d;
    logic [31:0]       tdata_q, tdata_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              szerr_q, szerr_d;
    logic              irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d;
`ifdef CAPTURE_TRIGGER_EN
    logic              trig_q, trig_d;
`endif

    logic          wr_ctrl, start_cmd, abort_cmd, handshake, busy, armed;
    logic [CW-1:0] nbeats;
    logic [31:0]   status;

    assign nbeats    = size_q[SIZE_W-1:2];
    assign wr_ctrl   = bus.reg_wr && (bus.reg_addr == REG_AW'(0));
    assign abort_cmd = wr_ctrl && bus.reg_wdata[1];
    assign start_cmd = wr_ctrl && bus.reg_wdata[0] && !bus.reg_wdata[1];
    assign handshake = tvalid_q && bus.m_axis_tready;
    assign busy      = (state_q != S_IDLE);
`ifdef CAPTURE_TRIGGER_EN
    assign armed     = (state_q == S_ARMED);
`else
    assign armed     = 1'b0;
`endif
    assign status    = {27'd0, armed, szerr_q, ovf_q, done_q, busy};

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        beat_d     = beat_q;
        count_d    = count_q;
        half_d     = half_q;
        half_vld_d = half_vld_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        szerr_d    = szerr_q;
        irq_d      = 1'b0;
        rdata_d    = 32'd0;
`ifdef CAPTURE_TRIGGER_EN
        trig_d     = bus.trig;
`endif

        if (handshake) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            if (count_q != '1) count_d = count_q + CW'(1);
        end

        // SIZE is frozen while a packet is in flight, so size_q doubles as the latched N.
        if (bus.reg_wr && (bus.reg_addr == REG_AW'(8)) && (state_q == S_IDLE))
            size_d = bus.reg_wdata[SIZE_W-1:0];

        case (state_q)
            S_IDLE: begin
                if (start_cmd) begin
                    done_d = 1'b0;
                    ovf_d  = 1'b0;
                    if (nbeats == '0) begin
                        szerr_d = 1'b1;
                    end else begin
                        szerr_d    = 1'b0;
                        count_d    = '0;
                        beat_d     = '0;
                        half_vld_d = 1'b0;
`ifdef CAPTURE_TRIGGER_EN
                        state_d    = S_ARMED;
`else
                        state_d    = S_CAPTURE;
`endif
                    end
                end
            end
`ifdef CAPTURE_TRIGGER_EN
            S_ARMED: begin
                if (abort_cmd)                  state_d = S_IDLE;
                else if (bus.trig && !trig_q)   state_d = S_CAPTURE;
            end
`endif
            S_CAPTURE, S_DRAIN: begin
                if (abort_cmd) begin
                    // A stalled beat is closed with tlast so the DMA still sees a framed packet.
                    half_vld_d = 1'b0;
                    if (tvalid_q && !bus.m_axis_tready) begin
                        tlast_d = 1'b1;
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (state_q == S_CAPTURE) begin
                    if (bus.adc_valid) begin
                        if (!half_vld_q) begin
                            half_d     = bus.adc_data;
                            half_vld_d = 1'b1;
                        end else begin
                            half_vld_d = 1'b0;
                            if (!tvalid_q || bus.m_axis_tready) begin
                                tdata_d  = {bus.adc_data, half_q};
                                tvalid_d = 1'b1;
                                tlast_d  = (beat_q == nbeats - CW'(1));
                                beat_d   = beat_q + CW'(1);
                                if (beat_q == nbeats - CW'(1)) state_d = S_DRAIN;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                end else if (handshake) begin
                    done_d  = 1'b1;
                    irq_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (handshake) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.reg_rd) begin
            case (bus.reg_addr)
                REG_AW'(4):  rdata_d = status;
                REG_AW'(8):  rdata_d = 32'(size_q);
                REG_AW'(12): rdata_d = 32'(count_q);
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            size_q     <= '0;
            beat_q     <= '0;
            count_q    <= '0;
            half_q     <= '0;
            half_vld_q <= 1'b0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            szerr_q    <= 1'b0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
`ifdef CAPTURE_TRIGGER_EN
            trig_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            beat_q     <= beat_d;
            count_q    <= count_d;
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            szerr_q    <= szerr_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
`ifdef CAPTURE_TRIGGER_EN
            trig_q     <= trig_d;
`endif
        end
    end

    assign bus.reg_rdata     = rdata_q;
    assign bus.m_axis_tdata  = tdata_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tlast  = tlast_q;
    assign bus.irq_done      = irq_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Scoreboard bench for adc_capture_ctrl: directed packets with hand-computed beats,
// a negedge monitor that pops and compares every accepted beat and checks stall stability.
module tb_adc_capture_ctrl;
    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } beat_t;

    logic  clk;
    logic  resetn;
    int    n_vec = 0;
    int    n_err = 0;
    int    irq_cnt = 0;
    logic  rand_rdy = 1'b0;
    logic  rdy_fix = 1'b0;
    beat_t sb[$];

    adc_capture_ctrl_if #(.REG_AW(4)) bus ();

    adc_capture_ctrl #(.SIZE_W(32), .REG_AW(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Sink ready: fixed level, or random with stall runs limited to three cycles.
    initial begin
        int zrun;
        zrun = 0;
        bus.m_axis_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) begin
                if (zrun >= 3) bus.m_axis_tready = 1'b1;
                else           bus.m_axis_tready = 1'($urandom_range(0, 1));
                zrun = bus.m_axis_tready ? 0 : zrun + 1;
            end else begin
                bus.m_axis_tready = rdy_fix;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compares accepted beats against the scoreboard and checks held data under stall.
    initial begin
        logic        stall_prev;
        logic [31:0] data_prev;
        beat_t       e;
        stall_prev = 1'b0;
        data_prev  = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_tvalid", 32'(bus.m_axis_tvalid), 32'd1);
                    check("stall_tdata", bus.m_axis_tdata, data_prev);
                end
                if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_beat: got 0x%08h last=%0b expected no beat",
                                 bus.m_axis_tdata, bus.m_axis_tlast);
                    end else begin
                        e = sb.pop_front();
                        check("beat_data", bus.m_axis_tdata, e.d);
                        check("beat_last", 32'(bus.m_axis_tlast), 32'(e.l));
                    end
                end
                stall_prev = bus.m_axis_tvalid && !bus.m_axis_tready;
                data_prev  = bus.m_axis_tdata;
                if (bus.irq_done) irq_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
        bus.reg_wr    = 1'b1;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        tick();
        bus.reg_wr    = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
        bus.reg_rd   = 1'b1;
        bus.reg_addr = a;
        tick();
        bus.reg_rd   = 1'b0;
        d = bus.reg_rdata;
    endtask

    task automatic adc_sample(input logic [15:0] s);
        bus.adc_valid = 1'b1;
        bus.adc_data  = s;
        tick();
        bus.adc_valid = 1'b0;
    endtask

    task automatic push(input logic [31:0] d, input logic l);
        beat_t b;
        b.d = d;
        b.l = l;
        sb.push_back(b);
    endtask

    task automatic wait_empty(input int maxc);
        int c;
        c = 0;
        while (sb.size() != 0 && c < maxc) begin
            tick();
            c++;
        end
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        logic [31:0] r;
        int          irq0;

        resetn        = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.reg_rd    = 1'b0;
        bus.reg_addr  = '0;
        bus.reg_wdata = '0;
        bus.adc_valid = 1'b0;
        bus.adc_data  = '0;
`ifdef CAPTURE_TRIGGER_EN
        bus.trig      = 1'b0;
`endif
        repeat (3) tick();
        check("rst_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(bus.m_axis_tlast), 32'd0);
        check("rst_tdata", bus.m_axis_tdata, 32'd0);
        check("rst_irq", 32'(bus.irq_done), 32'd0);
        resetn = 1'b1;
        tick();
        reg_read(4'h4, r);  check("rst_status", r, 32'h0);
        reg_read(4'h8, r);  check("rst_size", r, 32'h0);
        reg_read(4'hC, r);  check("rst_count", r, 32'h0);
        reg_read(4'h0, r);  check("ctrl_reads0", r, 32'h0);

        // Ramp packet, sink always ready; two surplus samples must be ignored.
        rdy_fix = 1'b1;
        irq0 = irq_cnt;
        reg_write(4'h8, 32'd16);
        reg_write(4'h0, 32'h1);
        push(32'h0001_0000, 1'b0);
        push(32'h0003_0002, 1'b0);
        push(32'h0005_0004, 1'b0);
        push(32'h0007_0006, 1'b1);
        adc_sample(16'd0);
        check("lat_first_half", 32'(bus.m_axis_tvalid), 32'd0);
        adc_sample(16'd1);
        check("lat_second_half", 32'(bus.m_axis_tvalid), 32'd1);
        for (int k = 2; k < 10; k++) adc_sample(16'(k));
        wait_empty(50);
        repeat (4) tick();
        reg_read(4'h4, r);  check("t1_status", r, 32'h2);
        reg_read(4'hC, r);  check("t1_count", r, 32'd4);
        check("t1_irq", 32'(irq_cnt - irq0), 32'd1);

        // Long packet, random ready, sample every 4 clocks.
        rand_rdy = 1'b1;
        irq0 = irq_cnt;
        reg_write(4'h8, 32'd4096);
        reg_write(4'h0, 32'h1);
        for (int j = 0; j < 1024; j++)
            push({16'(2 * j + 1), 16'(2 * j)}, (j == 1023));
        for (int k = 0; k < 2048; k++) begin
            adc_sample(16'(k));
            repeat (3) tick();
        end
        wait_empty(100);
        repeat (4) tick();
        rand_rdy = 1'b0;
        rdy_fix  = 1'b1;
        reg_read(4'h4, r);  check("t2_status", r, 32'h2);
        reg_read(4'hC, r);  check("t2_count", r, 32'd1024);
        check("t2_irq", 32'(irq_cnt - irq0), 32'd1);

        // Overflow: sink stalled while samples keep arriving.
        rdy_fix = 1'b0;
        repeat (3) tick();
        irq0 = irq_cnt;
        reg_write(4'h8, 32'd8);
        reg_write(4'h0, 32'h1);
        push(32'h0001_0000, 1'b0);
        push(32'h000b_000a, 1'b1);
        for (int k = 0; k < 10; k++) adc_sample(16'(k));
        check("t3_held_valid", 32'(bus.m_axis_tvalid), 32'd1);
        check("t3_held_data", bus.m_axis_tdata, 32'h0001_0000);
        rdy_fix = 1'b1;
        repeat (3) tick();
        adc_sample(16'h000a);
        adc_sample(16'h000b);
        wait_empty(20);
        repeat (4) tick();
        reg_read(4'h4, r);  check("t3_status", r, 32'h6);
        reg_read(4'hC, r);  check("t3_count", r, 32'd2);
        check("t3_irq", 32'(irq_cnt - irq0), 32'd1);

        // Abort with one beat stalled and an odd half-word pending.
        rdy_fix = 1'b0;
        repeat (3) tick();
        irq0 = irq_cnt;
        reg_write(4'h8, 32'd16);
        reg_write(4'h0, 32'h1);
        push(32'h0101_0100, 1'b1);
        adc_sample(16'h0100);
        adc_sample(16'h0101);
        adc_sample(16'h0102);
        reg_write(4'h0, 32'h2);
        tick();
        check("t4_pend_valid", 32'(bus.m_axis_tvalid), 32'd1);
        check("t4_pend_last", 32'(bus.m_axis_tlast), 32'd1);
        rdy_fix = 1'b1;
        wait_empty(20);
        repeat (4) tick();
        reg_read(4'h4, r);  check("t4_status", r, 32'h0);
        reg_read(4'hC, r);  check("t4_count", r, 32'd1);
        check("t4_irq", 32'(irq_cnt - irq0), 32'd0);

        // Zero-beat size, then START/SIZE while busy, ABORT in idle, START+ABORT together.
        reg_write(4'h8, 32'd2);
        reg_write(4'h0, 32'h1);
        repeat (2) tick();
        reg_read(4'h4, r);  check("t5_szerr", r & 32'h9, 32'h8);
        check("t5_no_tvalid", 32'(bus.m_axis_tvalid), 32'd0);
        irq0 = irq_cnt;
        reg_write(4'h8, 32'd8);
        reg_write(4'h0, 32'h1);
        reg_read(4'h4, r);  check("t5_busy", r, 32'h1);
        push(32'h0201_0200, 1'b0);
        push(32'h0203_0202, 1'b1);
        adc_sample(16'h0200);
        adc_sample(16'h0201);
        repeat (3) tick();
        reg_write(4'h0, 32'h1);
        reg_write(4'h8, 32'd40);
        reg_read(4'h8, r);  check("t5_size_locked", r, 32'd8);
        adc_sample(16'h0202);
        adc_sample(16'h0203);
        wait_empty(20);
        repeat (4) tick();
        reg_read(4'h4, r);  check("t5_status", r, 32'h2);
        reg_read(4'hC, r);  check("t5_count", r, 32'd2);
        check("t5_irq", 32'(irq_cnt - irq0), 32'd1);
        reg_write(4'h0, 32'h2);
        reg_read(4'h4, r);  check("abort_idle", r, 32'h2);
        reg_write(4'h0, 32'h3);
        tick();
        reg_read(4'h4, r);  check("start_abort", r, 32'h2);
        reg_read(4'h6, r);  check("unmapped_rd", r, 32'h0);

        // Reset in the middle of a packet drops tvalid without waiting for a clock.
        rdy_fix = 1'b0;
        repeat (3) tick();
        reg_write(4'h8, 32'd16);
        reg_write(4'h0, 32'h1);
        adc_sample(16'h0300);
        adc_sample(16'h0301);
        check("t6_pre_valid", 32'(bus.m_axis_tvalid), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_async_valid", 32'(bus.m_axis_tvalid), 32'd0);
        check("t6_async_data", bus.m_axis_tdata, 32'h0);
        tick();
        resetn = 1'b1;
        tick();
        reg_read(4'h4, r);  check("t6_status", r, 32'h0);
        reg_read(4'h8, r);  check("t6_size", r, 32'h0);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
